// File: rtl/drive_sequencer_if.sv
// Sensor-to-drive signal bundle for the drive sequencer.
// The master drives the sensor/control side and the slave drives the motor side.
interface drive_sequencer_if;
  logic       go;
  logic       obstacle;
  logic [1:0] track_mode;
  logic       line_lost;
  logic [1:0] motor_mode;
  logic [1:0] left;
  logic [1:0] right;
  logic [3:0] LED;
  logic       last_turn;

  modport master (
    output go, obstacle, track_mode, line_lost,
    input  motor_mode, left, right, LED, last_turn
  );

  modport slave (
    input  go, obstacle, track_mode, line_lost,
    output motor_mode, left, right, LED, last_turn
  );
endinterface

// File: rtl/drive_sequencer.sv
// Timed drive state machine: start/stop, obstacle hold, and line-loss recovery
// (reverse, then spin toward the last seen turn), with a search timeout fault.
module drive_sequencer #(
  parameter int unsigned HALT_CYC   = 10_000_000,
  parameter int unsigned REV_CYC    = 30_000_000,
  parameter int unsigned SEARCH_CYC = 150_000_000,
  parameter int unsigned CNT_W      = 32
) (
  input logic              clk,
  input logic              rst,
  drive_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] HALT_TC   = CNT_W'(HALT_CYC - 1);
  localparam logic [CNT_W-1:0] REV_TC    = CNT_W'(REV_CYC - 1);
  localparam logic [CNT_W-1:0] SEARCH_TC = CNT_W'(SEARCH_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [1:0] DIR_FWD = 2'b10;
  localparam logic [1:0] DIR_REV = 2'b01;
  localparam logic [1:0] DIR_BRK = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FOLLOW  = 3'd1,
    S_HALT    = 3'd2,
    S_REVERSE = 3'd3,
    S_SEARCH  = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_timer;
  logic             r_last_turn;

  logic [1:0] w_motor_mode;
  logic [1:0] w_left;
  logic [1:0] w_right;
  logic [3:0] w_led;

  // State, timer and turn memory; every state change clears the timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_timer     <= CNT_ZERO;
      r_last_turn <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_timer <= CNT_ZERO;
          if (bus.go) r_state <= S_FOLLOW;
        end
        S_FOLLOW: begin
          r_timer <= CNT_ZERO;
          if (bus.track_mode == 2'd1)      r_last_turn <= 1'b0;
          else if (bus.track_mode == 2'd2) r_last_turn <= 1'b1;
          if (bus.go)             r_state <= S_IDLE;
          else if (bus.obstacle)  r_state <= S_HALT;
          else if (bus.line_lost) r_state <= S_REVERSE;
        end
        S_HALT: begin
          // Any obstacle cycle restarts the full obstacle-free hold.
          if (bus.go) begin
            r_state <= S_IDLE;
            r_timer <= CNT_ZERO;
          end else if (bus.obstacle) begin
            r_timer <= CNT_ZERO;
          end else if (r_timer == HALT_TC) begin
            r_state <= S_FOLLOW;
            r_timer <= CNT_ZERO;
          end else begin
            r_timer <= r_timer + CNT_ONE;
          end
        end
        S_REVERSE: begin
          if (bus.go) begin
            r_state <= S_IDLE;
            r_timer <= CNT_ZERO;
          end else if (!bus.line_lost) begin
            r_state <= S_FOLLOW;
            r_timer <= CNT_ZERO;
          end else if (r_timer == REV_TC) begin
            r_state <= S_SEARCH;
            r_timer <= CNT_ZERO;
          end else begin
            r_timer <= r_timer + CNT_ONE;
          end
        end
        S_SEARCH: begin
          if (bus.go) begin
            r_state <= S_IDLE;
            r_timer <= CNT_ZERO;
          end else if (bus.obstacle) begin
            r_state <= S_HALT;
            r_timer <= CNT_ZERO;
          end else if (!bus.line_lost) begin
            r_state <= S_FOLLOW;
            r_timer <= CNT_ZERO;
          end else if (r_timer == SEARCH_TC) begin
            r_state <= S_FAULT;
            r_timer <= CNT_ZERO;
          end else begin
            r_timer <= r_timer + CNT_ONE;
          end
        end
        S_FAULT: begin
          r_timer <= CNT_ZERO;
          if (bus.go) r_state <= S_FOLLOW;
        end
        default: begin
          r_state <= S_IDLE;
          r_timer <= CNT_ZERO;
        end
      endcase
    end
  end

  // Output decode of the state; FOLLOW also steers from the live tracker input.
  always_comb begin
    w_motor_mode = 2'd0;
    w_left       = DIR_BRK;
    w_right      = DIR_BRK;
    w_led        = 4'b0000;
    case (r_state)
      S_IDLE: begin
        w_led = 4'b0000;
      end
      S_FOLLOW: begin
        w_led = 4'b0001;
        case (bus.track_mode)
          2'd1: begin
            w_left       = DIR_REV;
            w_right      = DIR_FWD;
            w_motor_mode = 2'd1;
          end
          2'd2: begin
            w_left       = DIR_FWD;
            w_right      = DIR_REV;
            w_motor_mode = 2'd2;
          end
          default: begin
            w_left       = DIR_FWD;
            w_right      = DIR_FWD;
            w_motor_mode = 2'd3;
          end
        endcase
      end
      S_HALT: begin
        w_led = 4'b1000;
      end
      S_REVERSE: begin
        w_left       = DIR_REV;
        w_right      = DIR_REV;
        w_motor_mode = 2'd3;
        w_led        = 4'b0100;
      end
      S_SEARCH: begin
        w_led = 4'b0010;
        if (r_last_turn) begin
          w_left       = DIR_FWD;
          w_right      = DIR_REV;
          w_motor_mode = 2'd2;
        end else begin
          w_left       = DIR_REV;
          w_right      = DIR_FWD;
          w_motor_mode = 2'd1;
        end
      end
      S_FAULT: begin
        w_led = 4'b1111;
      end
      default: begin
        w_led = 4'b0000;
      end
    endcase
  end

  assign bus.motor_mode = w_motor_mode;
  assign bus.left       = w_left;
  assign bus.right      = w_right;
  assign bus.LED        = w_led;
  assign bus.last_turn  = r_last_turn;

endmodule

// File: tb/tb_drive_sequencer.sv
// Directed bench for drive_sequencer with short timer parameters (4/5/8).
// Expected outputs are packed as {LED, left, right, motor_mode}.
module tb_drive_sequencer;

  localparam logic [9:0] O_IDLE   = {4'b0000, 2'b00, 2'b00, 2'd0};
  localparam logic [9:0] O_FOLL_L = {4'b0001, 2'b01, 2'b10, 2'd1};
  localparam logic [9:0] O_FOLL_R = {4'b0001, 2'b10, 2'b01, 2'd2};
  localparam logic [9:0] O_FOLL_S = {4'b0001, 2'b10, 2'b10, 2'd3};
  localparam logic [9:0] O_HALT   = {4'b1000, 2'b00, 2'b00, 2'd0};
  localparam logic [9:0] O_REV    = {4'b0100, 2'b01, 2'b01, 2'd3};
  localparam logic [9:0] O_SRCH_R = {4'b0010, 2'b10, 2'b01, 2'd2};
  localparam logic [9:0] O_FAULT  = {4'b1111, 2'b00, 2'b00, 2'd0};

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  drive_sequencer_if bus ();

  drive_sequencer #(
    .HALT_CYC  (4),
    .REV_CYC   (5),
    .SEARCH_CYC(8),
    .CNT_W     (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] outv();
    return {bus.LED, bus.left, bus.right, bus.motor_mode};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.go = 1'b0;
    bus.obstacle = 1'b0;
    bus.track_mode = 2'd0;
    bus.line_lost = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tests++;
    if (outv() !== O_IDLE) begin
      fails++;
      $display("FAIL reset_outputs got %b expected %b", outv(), O_IDLE);
    end
    tests++;
    if (bus.last_turn !== 1'b0) begin
      fails++;
      $display("FAIL reset_last_turn got %b expected 0", bus.last_turn);
    end
  endtask

  task automatic test_follow();
    bus.go = 1'b1;
    bus.track_mode = 2'd1;
    tick();
    bus.go = 1'b0;
    tests++;
    if (outv() !== O_FOLL_L || bus.last_turn !== 1'b0) begin
      fails++;
      $display("FAIL follow_left got %b/%b expected %b/0", outv(), bus.last_turn, O_FOLL_L);
    end
    bus.track_mode = 2'd2;
    #1;
    tests++;
    if (outv() !== O_FOLL_R) begin
      fails++;
      $display("FAIL follow_right got %b expected %b", outv(), O_FOLL_R);
    end
    tick();
    tests++;
    if (bus.last_turn !== 1'b1) begin
      fails++;
      $display("FAIL follow_last_turn got %b expected 1", bus.last_turn);
    end
    bus.track_mode = 2'd3;
    tick();
    tests++;
    if (outv() !== O_FOLL_S || bus.last_turn !== 1'b1) begin
      fails++;
      $display("FAIL follow_straight got %b/%b expected %b/1", outv(), bus.last_turn, O_FOLL_S);
    end
    bus.track_mode = 2'd0;
  endtask

  task automatic test_halt();
    bus.obstacle = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (outv() !== O_HALT) begin
        fails++;
        $display("FAIL halt_hold_%0d got %b expected %b", i, outv(), O_HALT);
      end
    end
    bus.obstacle = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (outv() !== O_HALT) begin
        fails++;
        $display("FAIL halt_count_%0d got %b expected %b", i, outv(), O_HALT);
      end
    end
    tick();
    tests++;
    if (outv() !== O_FOLL_S) begin
      fails++;
      $display("FAIL halt_exit got %b expected %b", outv(), O_FOLL_S);
    end
    // Glitch at hold count 2 must restart the full hold.
    bus.obstacle = 1'b1;
    tick();
    bus.obstacle = 1'b0;
    tick();
    tick();
    bus.obstacle = 1'b1;
    tick();
    bus.obstacle = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (outv() !== O_HALT) begin
        fails++;
        $display("FAIL glitch_hold_%0d got %b expected %b", i, outv(), O_HALT);
      end
    end
    tick();
    tests++;
    if (outv() !== O_FOLL_S) begin
      fails++;
      $display("FAIL glitch_exit got %b expected %b", outv(), O_FOLL_S);
    end
  endtask

  task automatic test_recovery_fault();
    bus.line_lost = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (outv() !== O_REV) begin
        fails++;
        $display("FAIL reverse_%0d got %b expected %b", i, outv(), O_REV);
      end
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (outv() !== O_SRCH_R) begin
        fails++;
        $display("FAIL search_%0d got %b expected %b", i, outv(), O_SRCH_R);
      end
      tick();
    end
    tick();
    tests++;
    if (outv() !== O_FAULT) begin
      fails++;
      $display("FAIL fault_latched got %b expected %b", outv(), O_FAULT);
    end
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    bus.line_lost = 1'b0;
    tests++;
    if (outv() !== O_FOLL_S) begin
      fails++;
      $display("FAIL fault_go got %b expected %b", outv(), O_FOLL_S);
    end
  endtask

  task automatic test_early_exit();
    bus.line_lost = 1'b1;
    tick();
    tick();
    tick();
    bus.line_lost = 1'b0;
    tick();
    tests++;
    if (outv() !== O_FOLL_S) begin
      fails++;
      $display("FAIL reverse_early_exit got %b expected %b", outv(), O_FOLL_S);
    end
    // A full 5-cycle reverse afterwards shows the timer was cleared.
    bus.line_lost = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (outv() !== O_REV) begin
        fails++;
        $display("FAIL reverse_rerun_%0d got %b expected %b", i, outv(), O_REV);
      end
      tick();
    end
    tick();
    tick();
    tick();
    bus.line_lost = 1'b0;
    tick();
    tests++;
    if (outv() !== O_FOLL_S) begin
      fails++;
      $display("FAIL search_early_exit got %b expected %b", outv(), O_FOLL_S);
    end
    bus.line_lost = 1'b1;
    tick();
    repeat (5) tick();
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (outv() !== O_SRCH_R) begin
        fails++;
        $display("FAIL search_rerun_%0d got %b expected %b", i, outv(), O_SRCH_R);
      end
      if (i < 7) tick();
    end
  endtask

  task automatic test_priority();
    bus.obstacle = 1'b1;
    bus.line_lost = 1'b0;
    tick();
    tests++;
    if (outv() !== O_HALT) begin
      fails++;
      $display("FAIL search_obstacle_wins got %b expected %b", outv(), O_HALT);
    end
    bus.obstacle = 1'b0;
    repeat (4) tick();
    tests++;
    if (outv() !== O_FOLL_S) begin
      fails++;
      $display("FAIL priority_follow got %b expected %b", outv(), O_FOLL_S);
    end
    bus.go = 1'b1;
    bus.obstacle = 1'b1;
    tick();
    bus.go = 1'b0;
    bus.obstacle = 1'b0;
    tests++;
    if (outv() !== O_IDLE) begin
      fails++;
      $display("FAIL go_beats_obstacle got %b expected %b", outv(), O_IDLE);
    end
  endtask

  task automatic test_async_reset();
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    bus.track_mode = 2'd2;
    tick();
    bus.track_mode = 2'd0;
    bus.line_lost = 1'b1;
    tick();
    tick();
    tests++;
    if (outv() !== O_REV || bus.last_turn !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_reverse got %b/%b expected %b/1", outv(), bus.last_turn, O_REV);
    end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (outv() !== O_IDLE) begin
      fails++;
      $display("FAIL async_reset_outputs got %b expected %b", outv(), O_IDLE);
    end
    tests++;
    if (bus.last_turn !== 1'b0) begin
      fails++;
      $display("FAIL async_reset_last_turn got %b expected 0", bus.last_turn);
    end
    bus.line_lost = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    tests++;
    if (outv() !== O_IDLE) begin
      fails++;
      $display("FAIL post_reset_idle got %b expected %b", outv(), O_IDLE);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_follow();
    test_halt();
    test_recovery_fault();
    test_early_exit();
    test_priority();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/drive_sequencer.md
Name: drive_sequencer

Overview:
- Sits between the sensor front-ends (ultrasonic stop flag, line-tracker state) and the motor PWM block / H-bridge direction pins of the car top level.
- Replaces the purely combinational direction decode with a timed state machine. It starts and stops the run on a button pulse, holds after an obstacle clears, and recovers a lost line by reversing and then spinning toward the last seen turn side.
- Flags search timeout as a fault.

Parameters:
- HALT_CYC, 10_000_000: consecutive obstacle-free cycles required before leaving HALT (100 ms at 100 MHz).
- REV_CYC, 30_000_000: cycles spent reversing after line loss.
- SEARCH_CYC, 150_000_000: maximum cycles spinning in SEARCH before FAULT.
- CNT_W, 32: timer width. Must hold max(HALT_CYC, REV_CYC, SEARCH_CYC).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous active-high reset.
- go  in  1  single-cycle start/stop pulse, already debounced and one-pulsed.
- obstacle  in  1  ultrasonic stop flag; 1 = object too close.
- track_mode  in  2  tracker state: 1 = TURN_LEFT, 2 = TURN_RIGHT, 0/3 = straight.
- line_lost  in  1  1 = no tracker sensor sees the line.
- motor_mode  out  2  speed/mode select to the PWM block: 0 = stop, 1 = left turn, 2 = right turn, 3 = running.
- left  out  2  left H-bridge {in1,in2}.
- right  out  2  right H-bridge {in1,in2}.
- LED  out  4  state indicator.
- last_turn  out  1  0 = left, 1 = right; direction used by SEARCH.

Behaviour:
- Direction encoding: forward 2'b10, reverse 2'b01, brake 2'b00.
- State and timer are registered. Outputs are a Moore decode of the state, except FOLLOW, which also decodes the live track_mode.
- Reset (asynchronous, active-high):
  - state = IDLE, timer = 0, last_turn = 0.
  - Outputs immediately: left = right = 00, motor_mode = 0, LED = 0000.
- IDLE: outputs stop, LED 0000. go -> FOLLOW.
- FOLLOW: LED 0001.
  - track_mode 1: left = 01, right = 10, motor_mode = 1.
  - track_mode 2: left = 10, right = 01, motor_mode = 2.
  - Otherwise: both 10, motor_mode = 3.
  - Every cycle, track_mode 1 sets last_turn = 0 and track_mode 2 sets last_turn = 1. Other values hold it.
- HALT: outputs stop, LED 1000.
  - timer clears while obstacle = 1 and increments while obstacle = 0.
  - When timer == HALT_CYC-1 and obstacle = 0 -> FOLLOW.
  - Any obstacle pulse restarts the full hold.
- REVERSE: left = right = 01, motor_mode = 3, LED 0100.
  - obstacle is ignored here (sensor faces forward).
  - line_lost = 0 -> FOLLOW immediately.
  - timer == REV_CYC-1 -> SEARCH.
- SEARCH: LED 0010.
  - last_turn = 0: spin left (left = 01, right = 10, motor_mode = 1).
  - last_turn = 1: spin right (left = 10, right = 01, motor_mode = 2).
  - last_turn is frozen.
  - line_lost = 0 -> FOLLOW.
  - timer == SEARCH_CYC-1 -> FAULT.
- FAULT: outputs stop, LED 1111, latched until go (-> FOLLOW) or reset.
- Transition priority from any state except IDLE/FAULT, evaluated each cycle:
  1. go -> IDLE.
  2. obstacle -> HALT. Applies in FOLLOW and SEARCH only; in HALT it only restarts the hold.
  3. line_lost -> REVERSE. FOLLOW only.
  4. The state's own timer exit.
- Timer rules:
  - The timer clears to 0 on every state change.
  - It counts +1 per cycle in REVERSE and SEARCH.
  - It is held at 0 in IDLE, FOLLOW and FAULT.
  - It never wraps: exits occur at the terminal count.
- HALT -> FOLLOW with line_lost = 1: FOLLOW is entered for one cycle, then REVERSE.
- Latency: every input-driven transition takes effect on the next clk edge. Outputs follow the new state in that same cycle.
- obstacle, line_lost and track_mode are synchronous to clk. go is a one-cycle pulse; a held go toggles IDLE/FOLLOW every cycle, and that is the caller's responsibility.

Test Plan (HALT_CYC = 4, REV_CYC = 5, SEARCH_CYC = 8):
1. Reset then go pulse, track_mode = 1 -> next cycle:
   - LED 0001, left = 01, right = 10, motor_mode = 1, last_turn = 0.
   - Then track_mode = 2 -> left = 10, right = 01, last_turn = 1.
2. In FOLLOW, obstacle high 3 cycles, then low:
   - LED 1000, outputs 00, through the high cycles.
   - FOLLOW resumes exactly 4 cycles after obstacle falls.
   - A 1-cycle obstacle glitch at count 2 restarts the 4-cycle hold.
3. line_lost held high with last_turn = 1:
   - REVERSE (both 01) for 5 cycles.
   - Then SEARCH spinning right for 8 cycles.
   - Then FAULT, LED 1111, outputs 00.
   - go -> FOLLOW.
4. line_lost drops at REVERSE cycle 2 -> FOLLOW the next cycle, timer back to 0. Same check at SEARCH cycle 3.
5. In SEARCH, obstacle and line_lost = 0 asserted in the same cycle -> HALT (obstacle wins). go together with obstacle in FOLLOW -> IDLE.
6. Assert rst asynchronously mid-REVERSE (between clock edges):
   - Outputs go to 00/0000 without waiting for clk.
   - State returns to IDLE and last_turn to 0.
